// File: rtl/pipelined_single_port_ram_pkg.sv
// pipelined_single_port_ram_pkg: shared state encoding, latency limits and address-width helper.
package pipelined_single_port_ram_pkg;
  typedef enum logic {INITIALIZING, OPERATIONAL} state_t;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;
  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/pipelined_single_port_ram_delay_line.sv
// delay_line: resettable valid bit with a parallel data register chain; zero stages is a wire.
module delay_line #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  output logic             delayed_valid,
  output logic [WIDTH-1:0] delayed_data
);
  if (STAGES == 0) begin : g_pass
    assign delayed_valid = data_valid;
    assign delayed_data  = data;
  end else begin : g_chain
    logic [STAGES-1:0] valid;
    logic [WIDTH-1:0]  stage [STAGES];
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) valid <= '0;
      else valid <= STAGES'({valid, data_valid});
    always_ff @(posedge clock) begin
      stage[0] <= data;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
    assign delayed_valid = valid[STAGES-1];
    assign delayed_data  = stage[STAGES-1];
  end
endmodule

// File: rtl/pipelined_single_port_ram.sv
// pipelined_single_port_ram: byte-masked single-port RAM with pipelined reads and a post-reset zeroing sweep.
module pipelined_single_port_ram
  import pipelined_single_port_ram_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 64,
  parameter int ADDRESS_WIDTH = clog2(DEPTH),
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          request_valid,
  output logic                          request_ready,
  input  logic                          request_write,
  input  logic [ADDRESS_WIDTH-1:0]      request_address,
  input  logic [WIDTH-1:0]              request_write_data,
  input  logic [WIDTH/BYTE_WIDTH-1:0]   request_byte_enable,
  output logic                          response_valid,
  output logic [WIDTH-1:0]              response_data
);
  localparam int ENABLE_COUNT = WIDTH / BYTE_WIDTH;

  if (WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY out of range");
  end

  state_t                   state, next_state;
  logic [ADDRESS_WIDTH-1:0] counter;
  logic [WIDTH-1:0]         memory [DEPTH];
  logic                     accept, in_range, read_valid;
  logic [WIDTH-1:0]         read_data, delayed_data;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state   <= INITIALIZING;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= (state == INITIALIZING) ? counter + ADDRESS_WIDTH'(1) : counter;
    end

  always_comb begin
    request_ready = state == OPERATIONAL;
    next_state    = (state == INITIALIZING && 32'(counter) == DEPTH - 1) ? OPERATIONAL : state;
  end

  assign accept   = request_valid & request_ready;
  assign in_range = 32'(request_address) < DEPTH;

  // The array itself is never reset; zeros come only from the sweep.
  always_ff @(posedge clock)
    if (state == INITIALIZING) memory[counter] <= '0;
    else if (accept && request_write && in_range)
      for (int i = 0; i < ENABLE_COUNT; i++)
        if (request_byte_enable[i])
          memory[request_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= request_write_data[i*BYTE_WIDTH +: BYTE_WIDTH];

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) read_valid <= 1'b0;
    else read_valid <= accept & ~request_write;

  always_ff @(posedge clock)
    if (accept && !request_write) read_data <= in_range ? memory[request_address] : '0;

  delay_line #(.WIDTH(WIDTH), .STAGES(READ_LATENCY - 1)) u_delay (
    .clock         (clock),
    .resetn        (resetn),
    .data_valid    (read_valid),
    .data          (read_data),
    .delayed_valid (response_valid),
    .delayed_data  (delayed_data)
  );

  assign response_data = response_valid ? delayed_data : '0;
endmodule
